// File: rtl/wb_dblbus_arbiter.sv
// Two-master priority arbiter for the dual (global/local) Wishbone bus.
// Master A has priority and is the default owner; a watchdog aborts unanswered cycles.
module wb_dblbus_arbiter #(
    parameter int AW      = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_a_cyc_gbl,
    input  logic          i_a_cyc_lcl,
    input  logic          i_a_stb_gbl,
    input  logic          i_a_stb_lcl,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_data,
    input  logic          i_b_cyc_gbl,
    input  logic          i_b_cyc_lcl,
    input  logic          i_b_stb_gbl,
    input  logic          i_b_stb_lcl,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic          o_wb_cyc_gbl,
    output logic          o_wb_cyc_lcl,
    output logic          o_wb_stb_gbl,
    output logic          o_wb_stb_lcl,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    output logic          o_timeout
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic          owner_q, owner_d;
    logic [CW-1:0] count_q, count_d;
    logic          timeout_q, timeout_d;

    logic          bus_en_s;
    logic          own_err_s;
    logic          bus_cyc_s;
    logic          a_req_s;
    logic          b_req_s;

    // Output mux: owner's request onto the bus, bus response back to the owner only
    always_comb begin
        bus_en_s  = i_rst_n & ~timeout_q;
        own_err_s = i_wb_err | (timeout_q & ~i_wb_ack);
        if (owner_q) begin
            o_wb_cyc_gbl = i_a_cyc_gbl & bus_en_s;
            o_wb_cyc_lcl = i_a_cyc_lcl & bus_en_s;
            o_wb_stb_gbl = i_a_stb_gbl & bus_en_s;
            o_wb_stb_lcl = i_a_stb_lcl & bus_en_s;
            o_wb_we      = i_a_we;
            o_wb_addr    = i_a_addr;
            o_wb_data    = i_a_data;
        end else begin
            o_wb_cyc_gbl = i_b_cyc_gbl & bus_en_s;
            o_wb_cyc_lcl = i_b_cyc_lcl & bus_en_s;
            o_wb_stb_gbl = i_b_stb_gbl & bus_en_s;
            o_wb_stb_lcl = i_b_stb_lcl & bus_en_s;
            o_wb_we      = i_b_we;
            o_wb_addr    = i_b_addr;
            o_wb_data    = i_b_data;
        end
        o_a_ack   = i_rst_n & owner_q & i_wb_ack;
        o_a_err   = i_rst_n & owner_q & own_err_s;
        o_a_stall = ~i_rst_n | ~owner_q | i_wb_stall;
        o_b_ack   = i_rst_n & ~owner_q & i_wb_ack;
        o_b_err   = i_rst_n & ~owner_q & own_err_s;
        o_b_stall = ~i_rst_n | owner_q | i_wb_stall;
        o_timeout = i_rst_n & timeout_q;
    end

    // Ownership hand-over and watchdog next state
    always_comb begin
        a_req_s   = i_a_cyc_gbl | i_a_cyc_lcl;
        b_req_s   = i_b_cyc_gbl | i_b_cyc_lcl;
        bus_cyc_s = o_wb_cyc_gbl | o_wb_cyc_lcl;
        owner_d   = owner_q;
        if (owner_q) begin
            owner_d = ~(~a_req_s & b_req_s);
        end else begin
            owner_d = ~b_req_s;
        end
        count_d = count_q;
        if ((TIMEOUT == 0) || !bus_cyc_s || i_wb_ack || i_wb_err || timeout_q) begin
            count_d = {CW{1'b0}};
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
        timeout_d = (TIMEOUT != 0) && bus_cyc_s && !i_wb_ack && !i_wb_err
                    && (count_q == CNT_LAST);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            owner_q   <= 1'b1;
            count_q   <= {CW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_dblbus_arbiter.sv
// Directed-vector bench for wb_dblbus_arbiter with a queue-based scoreboard.
module tb_wb_dblbus_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b1;
    logic          rst_n;
    logic          a_cyc_gbl, a_cyc_lcl, a_stb_gbl, a_stb_lcl, a_we;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_data;
    logic          b_cyc_gbl, b_cyc_lcl, b_stb_gbl, b_stb_lcl, b_we;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_data;
    logic          a_ack, a_stall, a_err, b_ack, b_stall, b_err;
    logic          wb_cyc_gbl, wb_cyc_lcl, wb_stb_gbl, wb_stb_lcl, wb_we;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_data;
    logic          wb_ack, wb_stall, wb_err, timeout;

    wb_dblbus_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_cyc_gbl(a_cyc_gbl), .i_a_cyc_lcl(a_cyc_lcl),
        .i_a_stb_gbl(a_stb_gbl), .i_a_stb_lcl(a_stb_lcl),
        .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data),
        .i_b_cyc_gbl(b_cyc_gbl), .i_b_cyc_lcl(b_cyc_lcl),
        .i_b_stb_gbl(b_stb_gbl), .i_b_stb_lcl(b_stb_lcl),
        .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err),
        .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err),
        .o_wb_cyc_gbl(wb_cyc_gbl), .o_wb_cyc_lcl(wb_cyc_lcl),
        .o_wb_stb_gbl(wb_stb_gbl), .o_wb_stb_lcl(wb_stb_lcl),
        .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [67:0] exp;
        logic [67:0] msk;
    } item_t;

    item_t q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    localparam int BUS_A    = 0;
    localparam int BUS_B    = 1;
    localparam int BUS_IDLE = 2;

    // Push the expected output picture for the current cycle, then advance one clock.
    // ea/eb = {ack, stall, err}; bus selects which master's request must be on the bus.
    task automatic vec(input string name, input int bus, input logic [2:0] ea,
                       input logic [2:0] eb, input logic eto);
        item_t it;
        it.name = name;
        it.msk  = {68{1'b1}};
        if (bus == BUS_A) begin
            it.exp[67:7] = {a_cyc_gbl, a_cyc_lcl, a_stb_gbl, a_stb_lcl, a_we, a_addr, a_data};
        end else if (bus == BUS_B) begin
            it.exp[67:7] = {b_cyc_gbl, b_cyc_lcl, b_stb_gbl, b_stb_lcl, b_we, b_addr, b_data};
        end else begin
            it.exp[67:7] = 61'd0;
            it.msk[63:7] = 57'd0;
        end
        it.exp[6:0] = {ea, eb, eto};
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT picture mid-cycle against the oldest expected entry
    always @(negedge clk) begin
        item_t       it;
        logic [67:0] act;
        if (q.size() > 0) begin
            it  = q.pop_front();
            act = {wb_cyc_gbl, wb_cyc_lcl, wb_stb_gbl, wb_stb_lcl, wb_we, wb_addr, wb_data,
                   a_ack, a_stall, a_err, b_ack, b_stall, b_err, timeout};
            n_vec++;
            if ((act & it.msk) !== (it.exp & it.msk)) begin
                n_miss++;
                $display("FAIL %s: got %h expected %h (mask %h)", it.name, act, it.exp, it.msk);
            end
        end
    end

    initial begin
        {a_cyc_gbl, a_cyc_lcl, a_stb_gbl, a_stb_lcl, a_we} = 5'd0;
        {b_cyc_gbl, b_cyc_lcl, b_stb_gbl, b_stb_lcl, b_we} = 5'd0;
        a_addr = 24'h00_0000; a_data = 32'h0000_0000;
        b_addr = 24'h00_0000; b_data = 32'h0000_0000;
        {wb_ack, wb_stall, wb_err} = 3'd0;
        rst_n = 1'b0;
        #1;

        // 1: reset with both masters requesting
        a_cyc_gbl = 1'b1; a_stb_gbl = 1'b1; a_addr = 24'h00_0100; a_data = 32'hAAAA_0001;
        b_cyc_gbl = 1'b1; b_stb_gbl = 1'b1; b_addr = 24'h00_0200; b_data = 32'hBBBB_0001;
        vec("rst0", BUS_IDLE, 3'b010, 3'b010, 1'b0);
        vec("rst1", BUS_IDLE, 3'b010, 3'b010, 1'b0);
        rst_n = 1'b1;
        vec("rst_rel_a_owns", BUS_A, 3'b000, 3'b010, 1'b0);
        {a_cyc_gbl, a_stb_gbl, b_cyc_gbl, b_stb_gbl} = 4'd0;
        vec("idle", BUS_A, 3'b000, 3'b010, 1'b0);

        // 2: A local read of 0x000004, ack two clocks later (stall passthrough in between)
        a_cyc_lcl = 1'b1; a_stb_lcl = 1'b1; a_addr = 24'h00_0004; a_we = 1'b0;
        vec("a_lcl_req", BUS_A, 3'b000, 3'b010, 1'b0);
        a_stb_lcl = 1'b0; wb_stall = 1'b1;
        vec("a_lcl_stall", BUS_A, 3'b010, 3'b010, 1'b0);
        wb_stall = 1'b0; wb_ack = 1'b1;
        vec("a_lcl_ack", BUS_A, 3'b100, 3'b010, 1'b0);
        a_cyc_lcl = 1'b0; wb_ack = 1'b0;
        vec("a_lcl_done", BUS_A, 3'b000, 3'b010, 1'b0);

        // 3: B global write while A idle: granted one clock later
        b_cyc_gbl = 1'b1; b_stb_gbl = 1'b1; b_we = 1'b1;
        b_addr = 24'h00_ABCD; b_data = 32'h1234_5678;
        vec("b_req_n", BUS_A, 3'b000, 3'b010, 1'b0);
        vec("b_grant_n1", BUS_B, 3'b010, 3'b000, 1'b0);
        b_stb_gbl = 1'b0; wb_ack = 1'b1;
        vec("b_ack", BUS_B, 3'b010, 3'b100, 1'b0);
        b_cyc_gbl = 1'b0; b_we = 1'b0; wb_ack = 1'b0;
        vec("b_drop", BUS_B, 3'b010, 3'b000, 1'b0);

        // 4: A active while B waits; then A waits behind B
        a_cyc_gbl = 1'b1; a_stb_gbl = 1'b1; a_addr = 24'h00_0010; a_we = 1'b1; a_data = 32'hCAFE_F00D;
        b_cyc_lcl = 1'b1; b_stb_lcl = 1'b1; b_addr = 24'h00_0020;
        vec("a_act_b_wait", BUS_A, 3'b000, 3'b010, 1'b0);
        a_stb_gbl = 1'b0; wb_ack = 1'b1;
        vec("a_ack_b_wait", BUS_A, 3'b100, 3'b010, 1'b0);
        a_cyc_gbl = 1'b0; a_we = 1'b0; wb_ack = 1'b0;
        vec("a_drop_m", BUS_A, 3'b000, 3'b010, 1'b0);
        vec("b_grant_m1", BUS_B, 3'b010, 3'b000, 1'b0);
        b_stb_lcl = 1'b0; a_cyc_gbl = 1'b1; a_stb_gbl = 1'b1; a_addr = 24'h00_0030;
        vec("a_wait_b", BUS_B, 3'b010, 3'b000, 1'b0);
        vec("a_wait_b2", BUS_B, 3'b010, 3'b000, 1'b0);
        b_cyc_lcl = 1'b0;
        vec("b_drop2", BUS_B, 3'b010, 3'b000, 1'b0);
        vec("a_grant_after_b", BUS_A, 3'b000, 3'b010, 1'b0);

        // 5: A holds cyc unanswered; watchdog fires in the 9th clock (count 0..7 first)
        a_stb_gbl = 1'b0;
        for (int i = 1; i < 8; i++) vec("a_hold", BUS_A, 3'b000, 3'b010, 1'b0);
        vec("a_timeout", BUS_IDLE, 3'b001, 3'b010, 1'b1);
        vec("a_after_timeout", BUS_A, 3'b000, 3'b010, 1'b0);

        // 6: second watchdog expiry, ack arrives in the timeout clock
        for (int i = 1; i < 8; i++) vec("a_hold2", BUS_A, 3'b000, 3'b010, 1'b0);
        wb_ack = 1'b1;
        vec("ack_in_timeout", BUS_IDLE, 3'b100, 3'b010, 1'b1);
        a_cyc_gbl = 1'b0; wb_ack = 1'b0;
        vec("idle2", BUS_A, 3'b000, 3'b010, 1'b0);

        // Reset in the middle of a B cycle hands the bus back to A
        b_cyc_gbl = 1'b1; b_stb_gbl = 1'b1; b_addr = 24'h00_0777;
        vec("b_req2", BUS_A, 3'b000, 3'b010, 1'b0);
        vec("b_own2", BUS_B, 3'b010, 3'b000, 1'b0);
        rst_n = 1'b0;
        vec("rst_mid_b", BUS_IDLE, 3'b010, 3'b010, 1'b0);
        rst_n = 1'b1;
        vec("rst_after_a_owns", BUS_A, 3'b000, 3'b010, 1'b0);

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
